// File: rtl/mem_responder_if.sv
// Request/response bus between the processor memory port and mem_responder.
// resp_err exists only when MEM_RANGE_CHECK_EN is defined.
interface mem_responder_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    logic                  req_valid;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  req_ready;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  busy;
`ifdef MEM_RANGE_CHECK_EN
    logic                  resp_err;
`endif

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, busy
`ifdef MEM_RANGE_CHECK_EN
        , input resp_err
`endif
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, busy
`ifdef MEM_RANGE_CHECK_EN
        , output resp_err
`endif
    );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory responder with a programmable wait-state handshake.
// Optional MEM_RANGE_CHECK_EN flags and suppresses accesses at addresses >= DEPTH.
module mem_responder #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 16,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    mem_responder_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e                state_q;
    logic [3:0]            cnt_q;
    logic                  write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  resp_valid_q;
    logic                  busy_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  ready_s;
    logic                  accept_s;
    logic                  commit_s;
    logic                  c_write_s;
    logic [ADDR_WIDTH-1:0] c_addr_s;
    logic [DATA_WIDTH-1:0] c_wdata_s;
    logic [IDX_W-1:0]      idx_s;
    logic                  c_err_s;

    assign ready_s  = (state_q == ST_IDLE) & ~rst_i;
    assign accept_s = bus.req_valid & ready_s;

    // Access happens on the edge entering RESP; with zero wait states that is the accept edge itself.
    assign commit_s = ~rst_i & (((WAIT_STATES == 0) & accept_s) |
                                ((state_q == ST_WAIT) & (cnt_q == 4'd1)));

    // Select the request fields used by the committing access
    always_comb begin
        c_write_s = write_q;
        c_addr_s  = addr_q;
        c_wdata_s = wdata_q;
        if (state_q == ST_IDLE) begin
            c_write_s = bus.req_write;
            c_addr_s  = bus.req_addr;
            c_wdata_s = bus.req_wdata;
        end else begin
            c_write_s = write_q;
            c_addr_s  = addr_q;
            c_wdata_s = wdata_q;
        end
    end

    assign idx_s = c_addr_s[IDX_W-1:0];

`ifdef MEM_RANGE_CHECK_EN
    assign c_err_s = (32'(c_addr_s) >= DEPTH);
`else
    assign c_err_s = 1'b0;
    logic unused_addr_hi_s;
    assign unused_addr_hi_s = ^c_addr_s[ADDR_WIDTH-1:IDX_W];
`endif

    // Storage array: not reset, written only by an in-range committing store
    always_ff @(posedge clk_i) begin
        if (commit_s && c_write_s && !c_err_s) begin
            mem_q[idx_s] <= c_wdata_s;
        end
    end

    // Handshake FSM with registered response outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        write_q <= bus.req_write;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        cnt_q   <= 4'(WAIT_STATES);
                        busy_q  <= 1'b1;
                        if (WAIT_STATES == 0) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 4'd1) begin
                        state_q      <= ST_RESP;
                        resp_valid_q <= 1'b1;
                        cnt_q        <= 4'd0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
            // Write responses keep the previous read data
            if (commit_s) begin
                err_q <= c_err_s;
                if (!c_write_s) begin
                    rdata_q <= c_err_s ? '0 : mem_q[idx_s];
                end else begin
                    rdata_q <= rdata_q;
                end
            end
        end
    end

    assign bus.req_ready  = ready_s;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.busy       = busy_q;
`ifdef MEM_RANGE_CHECK_EN
    assign bus.resp_err   = err_q;
`else
    logic unused_err_s;
    assign unused_err_s = err_q;
`endif
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance with two wait states, one with none.
module tb_mem_responder;
    localparam int DW = 16;
    localparam int AW = 16;
`ifdef MEM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus2 ();
    mem_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();

    mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(1024), .WAIT_STATES(2))
        u_ws2 (.clk_i(clk), .rst_i(rst), .bus(bus2.slave));
    mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(1024), .WAIT_STATES(0))
        u_ws0 (.clk_i(clk), .rst_i(rst), .bus(bus0.slave));

    typedef struct {
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        bit          sel;    // 1 = zero-wait instance
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;  // used for reads only
        bit          err;
    } vec_t;

    exp_t        sb_q[$];
    logic [15:0] last_rd [2];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic rdy(input bit s);
        return s ? bus0.req_ready : bus2.req_ready;
    endfunction
    function automatic logic rv(input bit s);
        return s ? bus0.resp_valid : bus2.resp_valid;
    endfunction
    function automatic logic bsy(input bit s);
        return s ? bus0.busy : bus2.busy;
    endfunction
    function automatic logic [15:0] rdat(input bit s);
        return s ? bus0.resp_rdata : bus2.resp_rdata;
    endfunction

    task automatic drive(input bit s, input logic v, input logic w, input logic [15:0] a, input logic [15:0] d);
        if (s) begin
            bus0.req_valid = v; bus0.req_write = w; bus0.req_addr = a; bus0.req_wdata = d;
        end else begin
            bus2.req_valid = v; bus2.req_write = w; bus2.req_addr = a; bus2.req_wdata = d;
        end
    endtask

    // Called at the first negedge after the accept edge
    task automatic finish_resp(input bit s);
        int   ws;
        int   n;
        exp_t e;
        ws = s ? 0 : 2;
        n  = 1;
        while (!rv(s) && n < 50) begin
            check("busy_wait", {30'd0, bsy(s), rdy(s)}, 32'd2);
            @(negedge clk);
            n++;
        end
        check("latency", n, ws + 1);
        check("busy_resp", {30'd0, bsy(s), rdy(s)}, 32'd2);
        if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard: response with no expected entry at %0t", $time);
        end else begin
            e = sb_q.pop_front();
            check("rdata", {16'd0, rdat(s)}, {16'd0, e.rdata});
`ifdef MEM_RANGE_CHECK_EN
            check("resp_err", {31'd0, (s ? bus0.resp_err : bus2.resp_err)}, {31'd0, e.err});
`endif
        end
        @(negedge clk);
        check("after_resp", {29'd0, rv(s), bsy(s), rdy(s)}, 32'd1);
    endtask

    task automatic do_req(input bit s, input bit w, input logic [15:0] a, input logic [15:0] d,
                          input logic [15:0] exp_rd, input bit exp_err, input bit abort);
        int  n;
        bit  seen;
        @(negedge clk);
        drive(s, 1'b1, w, a, d);
        n = 0;
        while (!rdy(s) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_idle", {31'd0, rdy(s)}, 32'd1);
        if (!abort) sb_q.push_back('{exp_rd, exp_err});
        @(negedge clk);
        // Scramble the request lines after accept; the response must not follow them
        drive(s, 1'b0, ~w, ~a, ~d);
        if (abort) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            last_rd[0] = 16'h0000;
            last_rd[1] = 16'h0000;
            seen = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (rv(s)) seen = 1'b1;
                @(negedge clk);
            end
            check("abort_no_resp", {31'd0, seen}, 32'd0);
        end else begin
            finish_resp(s);
        end
    endtask

    vec_t vecs [13];

    initial begin
        vec_t v;
        logic [15:0] er;

        vecs[0]  = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 16'h0005, 16'h1234, 16'h0000, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 16'h0005, 16'h0000, 16'h1234, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 16'h0003, 16'h3333, 16'h0000, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 16'h0007, 16'h7777, 16'h0000, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 16'h0003, 16'h0000, 16'h3333, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 16'h0008, 16'h5555, 16'h0000, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 16'h0001, 16'h0001, 16'h0000, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 16'h0401, 16'h0F0F, 16'h0000, RC};
        vecs[10] = '{1'b0, 1'b0, 16'h0001, 16'h0000, (RC ? 16'h0001 : 16'h0F0F), 1'b0};
        vecs[11] = '{1'b0, 1'b0, 16'h0401, 16'h0000, (RC ? 16'h0000 : 16'h0F0F), RC};
        vecs[12] = '{1'b1, 1'b1, 16'h03FF, 16'hA5A5, 16'h0000, 1'b0};

        last_rd[0] = 16'h0000;
        last_rd[1] = 16'h0000;
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        // Request held through reset must wait for the first cycle with reset low
        drive(1'b0, 1'b1, 1'b1, 16'h0020, 16'h2020);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_ws2", {13'd0, rdy(0), rv(0), bsy(0), rdat(0)}, 32'd0);
            check("rst_ws0", {13'd0, rdy(1), rv(1), bsy(1), rdat(1)}, 32'd0);
        end
        rst = 1'b0;
        #1;
        check("ready_after_rst", {30'd0, rdy(0), rdy(1)}, 32'd3);
        sb_q.push_back('{16'h0000, 1'b0});
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF);
        finish_resp(1'b0);

        for (int i = 0; i < 13; i++) begin
            v = vecs[i];
            if (v.wr) begin
                er = last_rd[v.sel];
            end else begin
                er = v.rdata;
                last_rd[v.sel] = v.rdata;
            end
            do_req(v.sel, v.wr, v.addr, v.wdata, er, v.err, 1'b0);
        end
        do_req(1'b1, 1'b0, 16'h03FF, 16'h0000, 16'hA5A5, 1'b0, 1'b0);
        last_rd[1] = 16'hA5A5;

        // Reset in the first wait cycle drops a pending store
        do_req(1'b0, 1'b1, 16'h0008, 16'hAAAA, 16'h0000, 1'b0, 1'b1);
        do_req(1'b0, 1'b0, 16'h0008, 16'h0000, 16'h5555, 1'b0, 1'b0);
        do_req(1'b0, 1'b0, 16'h0020, 16'h0000, 16'h2020, 1'b0, 1'b0);
        do_req(1'b1, 1'b0, 16'h0005, 16'h0000, 16'h1234, 1'b0, 1'b0);

        check("sb_drained", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Word-addressed 16-bit memory responder. Serves load/store and instruction-fetch requests issued by the processor's multicycle control path.
- Sits on the memory side of the processor memory interface and replaces the single-cycle ideal memory.
- Adds a programmable wait-state sequence, giving the controller a real request/response handshake to stall on.

Parameters:
- DATA_WIDTH, 16, word width of the memory and data ports.
- ADDR_WIDTH, 16, width of the request address.
- DEPTH, 1024, number of words implemented; power of two, at most 2**ADDR_WIDTH.
- WAIT_STATES, 2, extra cycles between request accept and response; range 0..15.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- ReqValid  in  1  initiator presents a request.
- ReqWrite  in  1  1 = store, 0 = load/fetch; sampled at accept.
- ReqAddr  in  ADDR_WIDTH  word address; sampled at accept.
- ReqWData  in  DATA_WIDTH  store data; sampled at accept.
- ReqReady  out  1  responder can accept a request this cycle.
- RespValid  out  1  one-cycle pulse; request complete.
- RespRData  out  DATA_WIDTH  load data; valid while RespValid is high for a read.
- Busy  out  1  high from accept through the response cycle.

Behaviour:
- Clock is Clock; reset is Reset, synchronous and active-high.
- States: IDLE, WAIT, RESP.
- Reset values: state = IDLE, ReqReady = 0 while Reset is high, RespValid = 0, RespRData = 0, Busy = 0, wait counter = 0. Memory array contents are not reset.
- ReqReady = (state == IDLE) & ~Reset.
- Accept occurs when ReqValid & ReqReady at a rising edge. At accept: latch ReqWrite, ReqAddr and ReqWData, and load counter = WAIT_STATES.
- IDLE -> RESP on accept if WAIT_STATES == 0; otherwise IDLE -> WAIT.
- WAIT: counter decrements each cycle; -> RESP on the edge where counter == 1.
- RESP: lasts exactly one cycle, with RespValid = 1; -> IDLE unconditionally.
- Memory access happens on the edge entering RESP:
  - A write updates mem[index].
  - A read registers mem[index] into RespRData.
- RespRData holds its value until the next read response. Write responses leave it unchanged.
- Latency: accept at edge k -> RespValid high during cycle k+1+WAIT_STATES.
- Maximum throughput: one request per WAIT_STATES+2 cycles. No back-to-back accept in the RESP cycle.
- Index = low log2(DEPTH) bits of the latched address. Upper bits are ignored (aliasing/wrap-around) unless the optional feature is enabled.
- Request inputs are ignored outside IDLE. Changes to ReqAddr or ReqWData after accept have no effect.
- Busy = (state != IDLE).
- Read-after-write to the same address in consecutive transactions returns the new data.
- Reset asserted in WAIT or RESP:
  - Returns to IDLE next edge and the pending request is dropped.
  - A write not yet committed is not performed.
  - RespValid = 0 next cycle.
- ReqValid held high across reset: not accepted until the first cycle with Reset low.

Optional Feature:
- Macro: MEM_RANGE_CHECK_EN.
- Defined:
  - Adds output port RespErr (1 bit, reset 0), valid with RespValid.
  - A latched address >= DEPTH gives RespErr = 1; a write is suppressed; a read returns RespRData = 0.
  - Timing is unchanged.
- Undefined: no RespErr port; out-of-range addresses alias via the low index bits.

Test Plan:
- Reset then idle: Reset high 3 cycles -> ReqReady = 0, RespValid = 0, RespRData = 0x0000, Busy = 0; ReqReady = 1 the cycle after Reset falls.
- Write then read, WAIT_STATES = 2: write 0xBEEF to addr 0x0010 accepted at edge k -> RespValid at cycle k+3. Read of 0x0010 -> RespRData = 0xBEEF with RespValid.
- Zero wait states (WAIT_STATES = 0): read addr 5 (preloaded 0x1234) accepted at edge k -> RespValid at cycle k+1 with 0x1234. Next accept possible at edge k+2, not earlier.
- Input change after accept: ReqAddr changed from 3 to 7 in the WAIT cycle -> response carries mem[3]; ReqReady = 0 throughout WAIT/RESP.
- Reset mid-operation: write 0xAAAA to addr 8 (old 0x5555), Reset asserted in the first WAIT cycle -> no RespValid. A later read of addr 8 returns 0x5555.
- Aliasing / range: DEPTH = 1024, write 0x0F0F to addr 0x0401.
  - Without MEM_RANGE_CHECK_EN: a read of addr 1 returns 0x0F0F.
  - With MEM_RANGE_CHECK_EN: RespErr = 1 and mem[1] is unchanged.
